seq_divider: RTL and testbench

Parametrised multi-cycle integer divider; successor of the fixed 8-bit start-level divider. Computes quotient and remainder of a W-bit dividend by a W-bit divisor using restoring shift-subtract with leading-zero normalisation of the divisor, so small divisors take more cycles and large ones fewer. It uses a pulse-start / one-cycle done handshake and flags divide-by-zero. Instantiated by datapath blocks needing occasional division without a combinational array divider.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_lzc.sv | 27 ++
 rtl/seq_divider.sv | 179 +++++++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Purpose: shared FSM state type and encoding width for seq_divider.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package seq_divider_pkg;

  localparam int STATE_W = 2;

  // NEG is only reachable when DIVIDER_SIGNED_EN is defined.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    NEG  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_lzc.sv
// Purpose: leading-zero counter; sizes the divisor normalisation shift and the iteration count.
// Latency: combinational.
// Backpressure: none.
// Ports: value (W) in; count (CW) leading zeros, 0 when value is 0; all_zero set when value is 0.
module lzc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Ascending scan: the last set bit seen is the most significant one,
  // so its position determines the final count.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      if (value[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/seq_divider.sv
// Purpose: multi-cycle restoring divider with normalised divisor; quotient, remainder, divide-by-zero flag.
// Latency: k+1 cycles from accepting edge to done (k = divisor leading zeros), +1 for signed; divide-by-zero done right after acceptance.
// Backpressure: none; start is only sampled in IDLE, requests in other states are dropped, not queued.
// Ports: clk, rst_n (async active-low); start, dividend[W], divisor[W] in;
//        quotient[W], remainder[W] (held until next accepted start), busy, done (1-cycle pulse), div_zero out.
// Optional: DIVIDER_SIGNED_EN adds input sgn (two's-complement operands, truncating division) and the NEG state.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef DIVIDER_SIGNED_EN
  input  logic         sgn,
`endif
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  state_t state, state_nxt;

  logic [W-1:0]  a_q, b_q, q_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  dvd_mag, dvs_mag;
  logic [CW-1:0] lz;
  logic          dvs_zero;

  logic          gt;
  logic [W-1:0]  a_nxt, q_nxt;
  logic          last;
  logic          go_neg;

`ifdef DIVIDER_SIGNED_EN
  logic sgn_q, neg_quo_q, neg_rem_q;

  // Magnitudes of the operands; the most-negative value maps onto itself,
  // which is exactly its unsigned magnitude.
  always_comb begin
    dvd_mag = (sgn && dividend[W-1]) ? -dividend : dividend;
    dvs_mag = (sgn && divisor[W-1])  ? -divisor  : divisor;
  end

  assign go_neg = sgn_q;
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
  end

  assign go_neg = 1'b0;
`endif

  lzc #(
    .W  (W),
    .CW (CW)
  ) u_lzc (
    .value    (dvs_mag),
    .count    (lz),
    .all_zero (dvs_zero)
  );

  // One restoring step; A never underflows because subtraction is gated by gt.
  always_comb begin
    gt    = (a_q >= b_q);
    a_nxt = gt ? (a_q - b_q) : a_q;
    q_nxt = {q_q[W-2:0], gt};
    last  = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dvs_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = go_neg ? NEG : DONE;
        end
      end
      NEG: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sgn_q     <= sgn;
            neg_quo_q <= sgn & (dividend[W-1] ^ divisor[W-1]);
            neg_rem_q <= sgn & dividend[W-1];
`endif
            if (dvs_zero) begin
              // Raw dividend is reported in both modes; no sign fix-up.
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              // Normalise so the divisor MSB is set: only k+1 quotient
              // bits can be non-zero, hence k+1 iterations.
              a_q   <= dvd_mag;
              b_q   <= dvs_mag << lz;
              q_q   <= '0;
              cnt_q <= lz;
            end
          end
        end
        CALC: begin
          a_q <= a_nxt;
          b_q <= b_q >> 1;
          q_q <= q_nxt;
          if (last) begin
            quotient  <= q_nxt;
            remainder <= a_nxt;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef DIVIDER_SIGNED_EN
        NEG: begin
          // Truncation toward zero: quotient sign from operand signs,
          // remainder follows the dividend. Most-negative / -1 wraps.
          quotient  <= neg_quo_q ? -q_q : q_q;
          remainder <= neg_rem_q ? -a_q : a_q;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Purpose: directed self-checking bench for seq_divider (W=8) with a result scoreboard.
// Latency: expectations counted in clock edges after the accepting edge.
// Backpressure: exercises start held high while the divider is busy.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;
`ifdef DIVIDER_SIGNED_EN
  logic         sgn;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;  // edges after the accepting edge until done is seen
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef DIVIDER_SIGNED_EN
    .sgn       (sgn),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request, record its expected result, and step through the
  // accepting edge. With keep set, start stays high with different operands.
  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int elat, input string tag,
                       input bit keep);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.tag = tag;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sb.push_back(e);
    tick();
    if (keep) begin
      dividend = 8'd50;
      divisor  = 8'd5;
    end else begin
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
    end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic issue_s(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int elat, input string tag);
    sgn = 1'b1;
    issue(dd, dv, eq, er, 1'b0, elat, tag, 1'b0);
    sgn = 1'b0;
  endtask
`endif

  // Wait (bounded) for done, compare against the oldest expectation,
  // then confirm the pulse ends and the result is held.
  task automatic wait_result();
    int   n  = 0;
    int   bc = 0;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      $display("FAIL scoreboard empty at result");
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, done, 1);
    chk({e.tag, "_quotient"}, quotient, e.q);
    chk({e.tag, "_remainder"}, remainder, e.r);
    chk({e.tag, "_div_zero"}, div_zero, e.dz);
    chk({e.tag, "_latency"}, n, e.lat);
    chk({e.tag, "_busy_cycles"}, bc, e.lat);
    chk({e.tag, "_busy_in_done"}, busy, 0);
    tick();
    chk({e.tag, "_done_pulse_end"}, done, 0);
    chk({e.tag, "_quotient_held"}, quotient, e.q);
  endtask

  initial begin
    exp_t e2;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIVIDER_SIGNED_EN
    sgn      = 1'b0;
`endif
    tick();
    tick();
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    tick();

    // Latency in edges after acceptance = leading zeros of divisor + 1;
    // divide-by-zero reports done straight after the accepting edge.
    issue(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 6, "d100_7",   1'b0); wait_result();
    issue(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, "d255_1",   1'b0); wait_result();
    issue(8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 1, "d200_200", 1'b0); wait_result();
    issue(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 0, "d5_0",     1'b0); wait_result();
    issue(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 7, "d9_3",     1'b0); wait_result();
    issue(8'd0,   8'd7,   8'd0,   8'd0,   1'b0, 6, "d0_7",     1'b0); wait_result();
    issue(8'd7,   8'd100, 8'd0,   8'd7,   1'b0, 2, "d7_100",   1'b0); wait_result();

    // start held high throughout: one result, then the held request is
    // accepted only from IDLE.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 6, "pulsed_100_7", 1'b1);
    wait_result();
    chk("pulsed_idle_busy", busy, 0);
    e2.q = 8'd10; e2.r = 8'd0; e2.dz = 1'b0; e2.lat = 6; e2.tag = "pulsed_50_5";
    sb.push_back(e2);
    tick();
    start = 1'b0;
    wait_result();

    // Asynchronous reset just before E3 of a running division.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_div_zero", div_zero, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    tick();
    issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 6, "post_rst_50_5", 1'b0); wait_result();

`ifdef DIVIDER_SIGNED_EN
    // Signed adds one NEG cycle: latency k+2.
    issue_s(8'hF9, 8'h02, 8'hFD, 8'hFF, 8, "s_m7_2");
    wait_result();
    issue_s(8'h80, 8'hFF, 8'h80, 8'h00, 9, "s_m128_m1");
    wait_result();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
